// File: rtl/user_trap_controller.sv
// User-mode trap sequencer: accepts exceptions, interrupts and URET, then walks
// the CSR file through the trap-info write, the ustatus update and the PC redirect.
module user_trap_controller #(
  parameter bit          VECTORED_EN  = 1'b1,
  parameter logic [11:0] USTATUS_ADDR = 12'h000
) (
  input  logic        core_clock,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        boundary_valid,
  input  logic [31:0] boundary_pc,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic        uret_valid,
  input  logic [31:0] csr_ustatus,
  input  logic [31:0] csr_uie,
  input  logic [31:0] csr_utvec,
  input  logic [31:0] csr_uepc,
  output logic        trap_csr_write,
  output logic [31:0] trap_uepc_data,
  output logic [31:0] trap_ucause_data,
  output logic [31:0] trap_utval_data,
  output logic        csr_write,
  output logic [11:0] csr_write_address,
  output logic [31:0] csr_write_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        flush
);

  typedef enum logic [2:0] {IDLE, TRAP_WR, STATUS_WR, RET_WR, REDIRECT} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_epc;
  logic [31:0] r_cause;
  logic [31:0] r_tval;
  logic [31:0] r_target;
  logic [31:0] r_ustatus;

  logic        w_extEn;
  logic        w_swEn;
  logic        w_timerEn;
  logic        w_irqAny;
  logic        w_takeExc;
  logic        w_takeIrq;
  logic        w_takeRet;
  logic [3:0]  w_code;
  logic [31:0] w_base;
  logic [31:0] w_irqTarget;
  logic [31:0] w_trapStatus;
  logic [31:0] w_retStatus;
  logic        w_unusedUie;

  // Only the three user interrupt enable bits matter here.
  assign w_unusedUie = ^{csr_uie[31:9], csr_uie[7:5], csr_uie[3:1]};

  assign w_extEn   = csr_ustatus[0] & csr_uie[8] & irq_ext;
  assign w_swEn    = csr_ustatus[0] & csr_uie[0] & irq_sw;
  assign w_timerEn = csr_ustatus[0] & csr_uie[4] & irq_timer;
  assign w_irqAny  = boundary_valid & (w_extEn | w_swEn | w_timerEn);

  assign w_takeExc = (r_state == IDLE) & exc_valid;
  assign w_takeIrq = (r_state == IDLE) & ~exc_valid & w_irqAny;
  assign w_takeRet = (r_state == IDLE) & ~exc_valid & ~w_irqAny & uret_valid;

  assign w_code      = w_extEn ? 4'd8 : (w_swEn ? 4'd0 : 4'd4);
  assign w_base      = {csr_utvec[31:2], 2'b00};
  // Mode values 2 and 3 fall back to direct; the add wraps modulo 2^32.
  assign w_irqTarget = (VECTORED_EN && (csr_utvec[1:0] == 2'b01))
                       ? w_base + {26'd0, w_code, 2'b00} : w_base;

  assign w_trapStatus = {r_ustatus[31:5], r_ustatus[0], r_ustatus[3:1], 1'b0};
  assign w_retStatus  = {r_ustatus[31:5], 1'b1, r_ustatus[3:1], r_ustatus[4]};

  always_ff @(posedge core_clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_takeExc || w_takeIrq) w_nextState = TRAP_WR;
        else if (w_takeRet)         w_nextState = RET_WR;
      end
      TRAP_WR:   w_nextState = STATUS_WR;
      STATUS_WR: w_nextState = REDIRECT;
      RET_WR:    w_nextState = REDIRECT;
      REDIRECT:  w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge core_clock) begin
    if (reset) begin
      r_epc     <= '0;
      r_cause   <= '0;
      r_tval    <= '0;
      r_target  <= '0;
      r_ustatus <= '0;
    end else if (w_takeExc) begin
      r_epc     <= exc_pc;
      r_cause   <= {28'd0, exc_cause};
      r_tval    <= exc_tval;
      r_target  <= w_base;
      r_ustatus <= csr_ustatus;
    end else if (w_takeIrq) begin
      r_epc     <= boundary_pc;
      r_cause   <= {1'b1, 27'd0, w_code};
      r_tval    <= '0;
      r_target  <= w_irqTarget;
      r_ustatus <= csr_ustatus;
    end else if (w_takeRet) begin
      r_target  <= csr_uepc;
      r_ustatus <= csr_ustatus;
    end
  end

  // Every output is a decode of the registered state; data ports idle at zero.
  assign trap_csr_write    = (r_state == TRAP_WR);
  assign trap_uepc_data    = trap_csr_write ? r_epc   : '0;
  assign trap_ucause_data  = trap_csr_write ? r_cause : '0;
  assign trap_utval_data   = trap_csr_write ? r_tval  : '0;
  assign csr_write         = (r_state == STATUS_WR) | (r_state == RET_WR);
  assign csr_write_address = csr_write ? USTATUS_ADDR : '0;
  assign csr_write_data    = (r_state == STATUS_WR) ? w_trapStatus :
                             (r_state == RET_WR)    ? w_retStatus  : '0;
  assign redirect_valid    = (r_state == REDIRECT);
  assign redirect_pc       = redirect_valid ? r_target : '0;
  assign busy              = (r_state != IDLE);
  assign flush             = busy;

endmodule

// File: tb/tb_user_trap_controller.sv
// Directed bench for user_trap_controller: a vectored and a direct-mode instance
// share stimulus; a per-cycle output scoreboard is filled at drive time.
module tb_user_trap_controller;

  typedef struct packed {
    logic        tw;
    logic [31:0] ue;
    logic [31:0] uc;
    logic [31:0] ut;
    logic        cw;
    logic [11:0] ca;
    logic [31:0] cd;
    logic        rv;
    logic [31:0] rp;
    logic        bz;
    logic        fl;
  } snap_t;

  logic        core_clock = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        boundary_valid;
  logic [31:0] boundary_pc;
  logic        irq_sw;
  logic        irq_timer;
  logic        irq_ext;
  logic        uret_valid;
  logic [31:0] csr_ustatus;
  logic [31:0] csr_uie;
  logic [31:0] csr_utvec;
  logic [31:0] csr_uepc;

  logic        twV, cwV, rvV, bzV, flV, twD, cwD, rvD, bzD, flD;
  logic [31:0] ueV, ucV, utV, cdV, rpV, ueD, ucD, utD, cdD, rpD;
  logic [11:0] caV, caD;
  snap_t       obsV, obsD;

  snap_t       qV[$];
  snap_t       qD[$];
  int          assertCount = 0;
  int          failCount = 0;
  logic [31:0] lastRedirV, lastRedirD, lastCsrData, lastCause;

  always #5 core_clock = ~core_clock;

  user_trap_controller #(.VECTORED_EN(1'b1), .USTATUS_ADDR(12'h000)) dutV (
    .core_clock(core_clock), .reset(reset), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .boundary_valid(boundary_valid),
    .boundary_pc(boundary_pc), .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .uret_valid(uret_valid), .csr_ustatus(csr_ustatus), .csr_uie(csr_uie),
    .csr_utvec(csr_utvec), .csr_uepc(csr_uepc), .trap_csr_write(twV),
    .trap_uepc_data(ueV), .trap_ucause_data(ucV), .trap_utval_data(utV),
    .csr_write(cwV), .csr_write_address(caV), .csr_write_data(cdV),
    .redirect_valid(rvV), .redirect_pc(rpV), .busy(bzV), .flush(flV));

  user_trap_controller #(.VECTORED_EN(1'b0), .USTATUS_ADDR(12'h000)) dutD (
    .core_clock(core_clock), .reset(reset), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .boundary_valid(boundary_valid),
    .boundary_pc(boundary_pc), .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .uret_valid(uret_valid), .csr_ustatus(csr_ustatus), .csr_uie(csr_uie),
    .csr_utvec(csr_utvec), .csr_uepc(csr_uepc), .trap_csr_write(twD),
    .trap_uepc_data(ueD), .trap_ucause_data(ucD), .trap_utval_data(utD),
    .csr_write(cwD), .csr_write_address(caD), .csr_write_data(cdD),
    .redirect_valid(rvD), .redirect_pc(rpD), .busy(bzD), .flush(flD));

  assign obsV = {twV, ueV, ucV, utV, cwV, caV, cdV, rvV, rpV, bzV, flV};
  assign obsD = {twD, ueD, ucD, utD, cwD, caD, cdD, rvD, rpD, bzD, flD};

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compareSnap(input string who, input snap_t o, input snap_t e);
    cmp({who, ".trap_csr_write"}, 32'(o.tw), 32'(e.tw));
    cmp({who, ".trap_uepc_data"}, o.ue, e.ue);
    cmp({who, ".trap_ucause_data"}, o.uc, e.uc);
    cmp({who, ".trap_utval_data"}, o.ut, e.ut);
    cmp({who, ".csr_write"}, 32'(o.cw), 32'(e.cw));
    cmp({who, ".csr_write_address"}, 32'(o.ca), 32'(e.ca));
    cmp({who, ".csr_write_data"}, o.cd, e.cd);
    cmp({who, ".redirect_valid"}, 32'(o.rv), 32'(e.rv));
    cmp({who, ".redirect_pc"}, o.rp, e.rp);
    cmp({who, ".busy"}, 32'(o.bz), 32'(e.bz));
    cmp({who, ".flush"}, 32'(o.fl), 32'(e.fl));
  endtask

  task automatic pushSnap(input bit vec, input snap_t s);
    if (vec) qV.push_back(s);
    else     qD.push_back(s);
  endtask

  // Reference model: predicts the cycle-by-cycle outputs that follow the next edge.
  task automatic predictFor(input bit vec);
    snap_t       s;
    logic        pe, ps, pt;
    logic [3:0]  code;
    logic [31:0] base, epc, cause, tval, tgt, st;
    bit          trap, ret;
    trap = 0; ret = 0; epc = '0; cause = '0; tval = '0; tgt = '0; code = '0;
    base = {csr_utvec[31:2], 2'b00};
    pe = csr_ustatus[0] && csr_uie[8] && irq_ext;
    ps = csr_ustatus[0] && csr_uie[0] && irq_sw;
    pt = csr_ustatus[0] && csr_uie[4] && irq_timer;
    if (exc_valid) begin
      epc = exc_pc; cause = {28'd0, exc_cause}; tval = exc_tval; tgt = base; trap = 1;
    end else if (boundary_valid && (pe || ps || pt)) begin
      code = pe ? 4'd8 : (ps ? 4'd0 : 4'd4);
      epc = boundary_pc; cause = 32'h8000_0000 | 32'(code); tval = '0;
      tgt = (vec && csr_utvec[1:0] == 2'b01) ? base + 32'(code) * 4 : base;
      trap = 1;
    end else if (uret_valid) begin
      tgt = csr_uepc; ret = 1;
    end
    if (trap) begin
      s = '0; s.tw = 1; s.ue = epc; s.uc = cause; s.ut = tval; s.bz = 1; s.fl = 1;
      pushSnap(vec, s);
      st = csr_ustatus; st[4] = csr_ustatus[0]; st[0] = 1'b0;
      s = '0; s.cw = 1; s.ca = 12'h000; s.cd = st; s.bz = 1; s.fl = 1;
      pushSnap(vec, s);
    end else if (ret) begin
      st = csr_ustatus; st[0] = csr_ustatus[4]; st[4] = 1'b1;
      s = '0; s.cw = 1; s.ca = 12'h000; s.cd = st; s.bz = 1; s.fl = 1;
      pushSnap(vec, s);
    end
    if (trap || ret) begin
      s = '0; s.rv = 1; s.rp = tgt; s.bz = 1; s.fl = 1;
      pushSnap(vec, s);
    end
    s = '0;
    pushSnap(vec, s);
  endtask

  task automatic applyStimulus();
    predictFor(1'b1);
    predictFor(1'b0);
  endtask

  task automatic checkOutput();
    snap_t e;
    if (qV.size() == 0 || qD.size() == 0) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL scoreboard_underflow observed=empty expected=entry");
    end else begin
      if (obsV.rv) lastRedirV = obsV.rp;
      if (obsD.rv) lastRedirD = obsD.rp;
      if (obsV.cw) lastCsrData = obsV.cd;
      if (obsV.tw) lastCause = obsV.uc;
      e = qV.pop_front();
      compareSnap("vec", obsV, e);
      e = qD.pop_front();
      compareSnap("dir", obsD, e);
    end
  endtask

  task automatic stepCycle();
    @(posedge core_clock);
    #1;
  endtask

  task automatic clearReq();
    exc_valid = 0; boundary_valid = 0; uret_valid = 0;
    irq_sw = 0; irq_timer = 0; irq_ext = 0;
  endtask

  task automatic runSequence();
    lastRedirV = '0; lastRedirD = '0; lastCsrData = '0; lastCause = '0;
    applyStimulus();
    stepCycle();
    clearReq();
    checkOutput();
    while (qV.size() > 0) begin
      stepCycle();
      checkOutput();
    end
  endtask

  initial begin
    reset = 1; clearReq();
    exc_cause = '0; exc_pc = '0; exc_tval = '0; boundary_pc = '0;
    csr_ustatus = '0; csr_uie = '0; csr_utvec = '0; csr_uepc = '0;
    stepCycle(); stepCycle();
    pushSnap(1'b1, '0); pushSnap(1'b0, '0);
    checkOutput();
    reset = 0;
    stepCycle();

    $display("[TB] exception");
    csr_ustatus = 32'h1; csr_utvec = 32'h0000_1000;
    exc_valid = 1; exc_cause = 4'd2; exc_pc = 32'h0000_0400; exc_tval = 32'hDEAD_BEEF;
    runSequence();
    cmp("exc.redirect", lastRedirV, 32'h0000_1000);
    cmp("exc.status", lastCsrData, 32'h0000_0010);

    $display("[TB] vectored timer irq");
    csr_ustatus = 32'h1; csr_uie = 32'h10; csr_utvec = 32'h0000_1001;
    irq_timer = 1; boundary_valid = 1; boundary_pc = 32'h200;
    runSequence();
    cmp("timer.vec_redirect", lastRedirV, 32'h0000_1010);
    cmp("timer.dir_redirect", lastRedirD, 32'h0000_1000);
    cmp("timer.cause", lastCause, 32'h8000_0004);

    $display("[TB] masked by ustatus");
    csr_ustatus = 32'h0; csr_uie = 32'h111;
    irq_sw = 1; irq_timer = 1; irq_ext = 1; boundary_valid = 1;
    runSequence();

    $display("[TB] interrupt priority");
    csr_ustatus = 32'h1; csr_uie = 32'h111; csr_utvec = 32'h0000_2001;
    irq_sw = 1; irq_timer = 1; irq_ext = 1; boundary_valid = 1; boundary_pc = 32'h300;
    runSequence();
    cmp("prio.cause", lastCause, 32'h8000_0008);

    $display("[TB] back-to-back software irq");
    csr_uie = 32'h11; irq_sw = 1; irq_timer = 1; boundary_valid = 1; boundary_pc = 32'h304;
    runSequence();

    $display("[TB] exception beats irq and uret");
    irq_ext = 1; boundary_valid = 1; uret_valid = 1; csr_uie = 32'h100;
    exc_valid = 1; exc_cause = 4'd7; exc_pc = 32'h0000_0500; exc_tval = 32'h1234_5678;
    runSequence();
    cmp("exc_prio.cause", lastCause, 32'h0000_0007);

    $display("[TB] irq beats uret");
    csr_ustatus = 32'h11; csr_utvec = 32'h0000_3003; csr_uie = 32'h10;
    irq_timer = 1; boundary_valid = 1; uret_valid = 1; boundary_pc = 32'h600;
    runSequence();
    cmp("mode3.redirect", lastRedirV, 32'h0000_3000);

    $display("[TB] uret");
    csr_ustatus = 32'h10; csr_uepc = 32'h0000_0404; uret_valid = 1;
    runSequence();
    cmp("uret.status", lastCsrData, 32'h0000_0011);
    cmp("uret.redirect", lastRedirV, 32'h0000_0404);

    $display("[TB] reset mid-sequence");
    csr_ustatus = 32'h1; csr_utvec = 32'h0000_4000;
    exc_valid = 1; exc_cause = 4'd3; exc_pc = 32'h700; exc_tval = 32'h55;
    applyStimulus();
    stepCycle();
    exc_cause = 4'd5; exc_pc = 32'h900;
    checkOutput();
    stepCycle();
    checkOutput();
    reset = 1; exc_valid = 0;
    qV.delete(); qD.delete();
    for (int i = 0; i < 3; i++) begin
      pushSnap(1'b1, '0); pushSnap(1'b0, '0);
    end
    stepCycle();
    checkOutput();
    reset = 0;
    stepCycle();
    checkOutput();
    stepCycle();
    checkOutput();

    $display("[TB] vectored wrap");
    csr_ustatus = 32'h1; csr_uie = 32'h100; csr_utvec = 32'hFFFF_FFFD;
    irq_ext = 1; boundary_valid = 1; boundary_pc = 32'h800;
    runSequence();
    cmp("wrap.vec_redirect", lastRedirV, 32'h0000_001C);
    cmp("wrap.dir_redirect", lastRedirD, 32'hFFFF_FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
